// File: rtl/mix_col_ser_pkg.sv
// Shared types and constants for the column serializer: occupancy states,
// byte width and rows per column.
package mix_col_ser_pkg;

   localparam int unsigned ByteW = 8;
   localparam int unsigned Rows  = 4;

   typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

   typedef logic [Rows-1:0][ByteW-1:0] col_t;

endpackage

// File: rtl/col_buf.sv
// Two-entry column ring buffer with 1-bit write/read pointers and an
// occupancy FSM that reports the current column count.
module col_buf
   import mix_col_ser_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  col_t       wr_col,
   input  logic       pop,
   output col_t       rd_col,
   output logic [1:0] count
);

   occ_e state_q, state_d;
   logic wr_ptr_q, wr_ptr_d;
   logic rd_ptr_q, rd_ptr_d;
   col_t mem_q [2];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StEmpty;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_col;
         end
      end
   end

   // The owner never writes when FULL nor pops when EMPTY.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q ^ wr_en;
      rd_ptr_d = rd_ptr_q ^ pop;
      unique case (state_q)
         StEmpty: if (wr_en) state_d = StOne;
         StOne: begin
            if (wr_en && !pop) begin
               state_d = StFull;
            end else if (!wr_en && pop) begin
               state_d = StEmpty;
            end
         end
         StFull:  if (pop) state_d = StOne;
         default: state_d = StEmpty;
      endcase
   end

   always_comb begin
      count = 2'd0;
      unique case (state_q)
         StEmpty: count = 2'd0;
         StOne:   count = 2'd1;
         StFull:  count = 2'd2;
         default: count = 2'd0;
      endcase
   end

   assign rd_col = mem_q[rd_ptr_q];

endmodule

// File: rtl/mix_col_ser.sv
// Serializes 4-byte mix_col output columns into a byte stream with
// valid/ready handshake and a last-byte-of-state marker.
module mix_col_ser
   import mix_col_ser_pkg::*;
#(
   parameter int unsigned NCOL  = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [ByteW-1:0] d0_in,
   input  logic [ByteW-1:0] d1_in,
   input  logic [ByteW-1:0] d2_in,
   input  logic [ByteW-1:0] d3_in,
   output logic             load_rdy,
   output logic [ByteW-1:0] d_out,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic             last_out
);

   localparam int unsigned ColW = (NCOL > 1) ? $clog2(NCOL) : 1;

   logic [1:0]      count;
   col_t            rd_col;
   col_t            wr_col;
   logic            push, xfer, pop;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [ColW-1:0] col_cnt_q, col_cnt_d;

   assign wr_col = {d3_in, d2_in, d1_in, d0_in};

   // No bypass: a full buffer refuses load even while the head is popping.
   assign load_rdy = (count < 2'(DEPTH));
   assign push     = load && load_rdy;
   assign out_vld  = (count != 2'd0);
   assign xfer     = out_vld && out_rdy;
   assign pop      = xfer && (byte_idx_q == 2'd3);

   col_buf u_col_buf (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (push),
      .wr_col (wr_col),
      .pop    (pop),
      .rd_col (rd_col),
      .count  (count)
   );

   assign d_out    = rd_col[byte_idx_q];
   assign last_out = out_vld && (col_cnt_q == ColW'(NCOL - 1)) && (byte_idx_q == 2'd3);

   always_comb begin
      byte_idx_d = byte_idx_q;
      col_cnt_d  = col_cnt_q;
      if (xfer) begin
         byte_idx_d = byte_idx_q + 2'd1;
      end
      if (pop) begin
         col_cnt_d = (col_cnt_q == ColW'(NCOL - 1)) ? '0 : col_cnt_q + ColW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         byte_idx_q <= 2'd0;
         col_cnt_q  <= '0;
      end else begin
         byte_idx_q <= byte_idx_d;
         col_cnt_q  <= col_cnt_d;
      end
   end

endmodule

// File: tb/tb_mix_col_ser.sv
// Scoreboard bench for mix_col_ser: expected bytes are queued when a column
// is accepted and compared while the DUT presents them.
module tb_mix_col_ser;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic [7:0] d0_in = '0, d1_in = '0, d2_in = '0, d3_in = '0;
   logic       load_rdy;
   logic [7:0] d_out;
   logic       out_vld;
   logic       out_rdy = 1'b0;
   logic       last_out;

   always #5 clk = ~clk;

   mix_col_ser #(.NCOL(4), .DEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .d0_in    (d0_in),
      .d1_in    (d1_in),
      .d2_in    (d2_in),
      .d3_in    (d3_in),
      .load_rdy (load_rdy),
      .d_out    (d_out),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .last_out (last_out)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: {last, byte} per expected output, plus occupancy bookkeeping.
   logic [8:0] sb_q[$];
   int         m_count = 0;
   int         m_byte  = 0;
   int         m_col   = 0;

   logic [31:0] tbl [8] = '{32'h47_37_94_ed, 32'h40_d4_e4_a5, 32'ha3_70_3a_a6,
                            32'h4c_9f_42_bc, 32'h8e_4d_a1_bc, 32'h11_22_33_44,
                            32'h55_66_77_88, 32'h99_aa_bb_cc};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      load = 1'b1;
      out_rdy = 1'b1;
      {d0_in, d1_in, d2_in, d3_in} = 32'hdead_beef;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      load = 1'b0;
      out_rdy = 1'b0;
      sb_q.delete();
      m_count = 0;
      m_byte = 0;
      m_col = 0;
      check("rst_vld", {31'd0, out_vld}, 32'd0);
      check("rst_last", {31'd0, last_out}, 32'd0);
      check("rst_load_rdy", {31'd0, load_rdy}, 32'd1);
      check("rst_d_out", {24'd0, d_out}, 32'd0);
   endtask

   // One clock: drive at negedge, compare outputs, then advance the model.
   task automatic cycle(input logic ld, input logic [31:0] col, input logic rdy,
                        output logic acc);
      logic xfer;
      load = ld;
      {d0_in, d1_in, d2_in, d3_in} = col;
      out_rdy = rdy;
      check("load_rdy", {31'd0, load_rdy}, {31'd0, m_count < 2});
      if (m_count > 0) begin
         check("vld", {31'd0, out_vld}, 32'd1);
         check("d_out", {24'd0, d_out}, {24'd0, sb_q[0][7:0]});
         check("last", {31'd0, last_out}, {31'd0, sb_q[0][8]});
      end else begin
         check("vld", {31'd0, out_vld}, 32'd0);
         check("last", {31'd0, last_out}, 32'd0);
      end
      xfer = (m_count > 0) && rdy;
      acc  = ld && (m_count < 2);
      @(posedge clk);
      if (xfer) begin
         void'(sb_q.pop_front());
         if (m_byte == 3) begin
            m_byte = 0;
            m_count--;
         end else begin
            m_byte++;
         end
      end
      if (acc) begin
         for (int r = 0; r < 4; r++) begin
            sb_q.push_back({(r == 3) && (m_col == 3), col[31-8*r -: 8]});
         end
         m_col = (m_col + 1) % 4;
         m_count++;
      end
      @(negedge clk);
   endtask

   // Offer columns whenever the model says there is room; returns cycles used.
   task automatic feed(input int base, input int n, output int cycles);
      int  ci;
      logic acc;
      ci = 0;
      cycles = 0;
      while ((ci < n || m_count > 0) && cycles < 200) begin
         cycle(ci < n, (ci < n) ? tbl[base + ci] : 32'h0, 1'b1, acc);
         if (acc) ci++;
         cycles++;
      end
      check("feed_done", cycles, cycles < 200 ? cycles : 32'd0);
   endtask

   task automatic idle(input int n, input logic rdy);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, rdy, acc);
   endtask

   initial begin
      int   cyc;
      logic acc;

      do_reset();

      // Single column, latency and drain.
      cycle(1'b1, 32'h8e4da1bc, 1'b1, acc);
      idle(5, 1'b1);

      // Full 16-byte state back to back.
      do_reset();
      feed(0, 4, cyc);
      check("throughput", cyc, 32'd17);

      // Backpressure after two bytes; third column must be refused.
      do_reset();
      cycle(1'b1, tbl[5], 1'b0, acc);
      cycle(1'b1, tbl[6], 1'b1, acc);
      cycle(1'b1, tbl[7], 1'b1, acc);
      check("third_refused", {31'd0, acc}, 32'd0);
      for (int i = 0; i < 5; i++) cycle(1'b1, tbl[7], 1'b0, acc);
      idle(10, 1'b1);

      // Load and pop together in ONE: no bubble.
      do_reset();
      cycle(1'b1, tbl[1], 1'b1, acc);
      idle(3, 1'b1);
      cycle(1'b1, tbl[2], 1'b1, acc);
      check("one_count", m_count, 32'd1);
      check("no_bubble", {24'd0, d_out}, {24'd0, tbl[2][31:24]});
      idle(5, 1'b1);

      // Reset mid-state must clear the column counter and buffered bytes.
      do_reset();
      feed(0, 3, cyc);
      cycle(1'b1, tbl[3], 1'b1, acc);
      idle(2, 1'b1);
      do_reset();
      idle(2, 1'b1);
      feed(4, 1, cyc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mix_col_ser.md
MIX_COL_SER -- requirements
Module: mix_col_ser

Interface
REQ-001 The block SHALL have parameter NCOL, default 4, meaning the number of columns per AES state used to generate last_out.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the column buffer depth in columns; only 2 is required.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have port load, input, 1, offering a parallel column on d0_in..d3_in.
REQ-006 The block SHALL have ports d0_in, d1_in, d2_in, d3_in, input, 8 each, column bytes for rows 0..3, as produced by mix_col.
REQ-007 The block SHALL have port load_rdy, output, 1, high when a column can be accepted.
REQ-008 The block SHALL have port d_out, output, 8, the serial byte.
REQ-009 The block SHALL have port out_vld, output, 1, meaning d_out holds a valid byte.
REQ-010 The block SHALL have port out_rdy, input, 1, the downstream acceptance signal.
REQ-011 The block SHALL have port last_out, output, 1, marking byte 3 of column NCOL-1, i.e. the last byte of a 16-byte state.

Function
REQ-012 A column SHALL be accepted on a rising edge where load=1 and load_rdy=1; load while load_rdy=0 SHALL be ignored, with no state change.
REQ-013 load_rdy SHALL equal (count < DEPTH), decoded from registered count only; there is no bypass, so a full buffer rejects load even during a same-cycle pop.
REQ-014 The occupancy FSM SHALL have states EMPTY, ONE and FULL.
REQ-015 FSM transitions:
- load only: count+1.
- pop only: count-1.
- load and pop in the same cycle in state ONE: stay in ONE.
REQ-016 Storage SHALL be a 2-entry ring with a 1-bit write pointer and a 1-bit read pointer, each wrapping modulo 2.
REQ-017 out_vld SHALL be 1 whenever count>0.
REQ-018 d_out SHALL equal the head column's byte selected by a 2-bit byte index (0->d0, 1->d1, 2->d2, 3->d3).
REQ-019 d_out and out_vld SHALL be decoded from registers only, with no combinational path from any input.
REQ-020 A transfer SHALL occur when out_vld=1 and out_rdy=1 on a rising edge; the byte index then increments.
REQ-021 On a transfer with byte index 3, the byte index SHALL wrap to 0, the head column SHALL be popped, and the column counter SHALL increment modulo NCOL.
REQ-022 While out_vld=1 and out_rdy=0, d_out, out_vld and last_out SHALL hold stable.
REQ-023 Latency: a column accepted at edge N SHALL present d0 with out_vld=1 in cycle N+1 when the buffer was empty.
REQ-024 Throughput with out_rdy held high SHALL be 1 byte per cycle, sustained indefinitely with load asserted whenever load_rdy=1.
REQ-025 last_out SHALL equal out_vld AND (column counter = NCOL-1) AND (byte index = 3).
REQ-026 Data bytes SHALL pass unmodified; the block performs no arithmetic on data.

Reset
REQ-027 When rst=0 at a rising edge, the block SHALL set:
- count, both pointers, byte index and column counter to 0;
- out_vld=0, last_out=0, load_rdy=1.
REQ-028 When rst=0 at a rising edge, d_out SHALL read 8'h00, with buffer contents cleared.
REQ-029 Reset mid-column or mid-state SHALL discard all buffered bytes, with no residual output after reset release.
REQ-030 Reset SHALL take priority over a simultaneous load or transfer.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (EMPTY/ONE/FULL), the byte-width constant 8, and the rows-per-column constant 4.
REQ-032 The 2-entry column buffer SHALL be a single sub-module, col_buf, providing write port, read pointer and count; the byte sequencer and column counter SHALL live in mix_col_ser.

Verification
REQ-033 Single column: load {8e,4d,a1,bc} with out_rdy=1 -> d_out 8e,4d,a1,bc in cycles N+1..N+4, out_vld low at N+5.
REQ-034 Full state: load 4 columns back-to-back, {47,37,94,ed}, {40,d4,e4,a5}, {a3,70,3a,a6}, {4c,9f,42,bc}, with out_rdy=1 -> 16 bytes in order, last_out=1 only on byte bc.
REQ-035 Backpressure: out_rdy=0 for 5 cycles after byte 2 -> d_out held at byte 2; load_rdy=0 after the second column is loaded; third load ignored.
REQ-036 Simultaneous load and pop in ONE: load the new column on the edge byte 3 is accepted -> next cycle d_out = new d0, count stays ONE, no bubble.
REQ-037 Reset mid-operation: rst=0 for 1 cycle after byte 1 -> out_vld=0 and load_rdy=1 next cycle, d_out=00; the following column starts at byte 0 and column counter 0.
